// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-accumulate and iterative divide unit for the EX stage.
// Holds the architectural HI/LO pair and stalls the pipeline via Busy while an operation is in flight.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHiEn,
  input  logic             WriteLoEn,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadHi,
  output logic [WIDTH-1:0] ReadLo,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [PW-1:0]    prodReg;
  logic [1:0]       accMode;
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] rawA;
  logic [CW-1:0]    cnt;
  logic             negQ;
  logic             negR;
  logic             divZero;

  logic [PW-1:0]    extA;
  logic [PW-1:0]    extB;
  logic [PW-1:0]    product;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic [PW-1:0]    hiLo;
  logic [PW-1:0]    accResult;
  logic [WIDTH-1:0] qFix;
  logic [WIDTH-1:0] rFix;

  // Operand conditioning, product formation and one restoring-division step.
  always_comb begin
    signA     = ~Op[0] & A[WIDTH-1];
    signB     = ~Op[0] & B[WIDTH-1];
    extA      = {{WIDTH{signA}}, A};
    extB      = {{WIDTH{signB}}, B};
    product   = extA * extB;
    absA      = signA ? WIDTH'(-A) : A;
    absB      = signB ? WIDTH'(-B) : B;
    remShift  = {remReg, quoReg[WIDTH-1]};
    remDiff   = remShift - {1'b0, divisorReg};
    hiLo      = {ReadHi, ReadLo};
    accResult = prodReg;
    case (accMode)
      2'b01:   accResult = hiLo + prodReg;
      2'b10:   accResult = hiLo - prodReg;
      default: accResult = prodReg;
    endcase
    qFix = negQ ? WIDTH'(-quoReg) : quoReg;
    rFix = negR ? WIDTH'(-remReg) : remReg;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      ReadHi     <= '0;
      ReadLo     <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      prodReg    <= '0;
      accMode    <= 2'b00;
      divisorReg <= '0;
      quoReg     <= '0;
      remReg     <= '0;
      rawA       <= '0;
      cnt        <= '0;
      negQ       <= 1'b0;
      negR       <= 1'b0;
      divZero    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (WriteHiEn) ReadHi <= WriteData;
          if (WriteLoEn) ReadLo <= WriteData;
          if (Start) begin
            Busy <= 1'b1;
            if (Op[2:1] != 2'b11) begin
              state   <= MUL;
              prodReg <= product;
              accMode <= Op[2:1];
            end else begin
              state      <= DIV;
              divisorReg <= absB;
              quoReg     <= absA;
              remReg     <= '0;
              rawA       <= A;
              cnt        <= CW'(WIDTH);
              negQ       <= signA ^ signB;
              negR       <= signA;
              divZero    <= (B == '0);
            end
          end
        end
        MUL: begin
          {ReadHi, ReadLo} <= accResult;
          Busy             <= 1'b0;
          Done             <= 1'b1;
          state            <= IDLE;
        end
        DIV: begin
          // Keep the trial difference only when it did not borrow.
          if (!remDiff[WIDTH]) begin
            remReg <= remDiff[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b1};
          end else begin
            remReg <= remShift[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (divZero) begin
            ReadLo <= '1;
            ReadHi <= rawA;
          end else begin
            ReadLo <= qFix;
            ReadHi <= rFix;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: arithmetic reference model feeds an expected-result queue,
// a Done-triggered monitor pops and compares HI/LO.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        WriteHiEn = 1'b0;
  logic        WriteLoEn = 1'b0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadHi;
  logic [31:0] ReadLo;
  logic        Busy;
  logic        Done;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .WriteHiEn(WriteHiEn), .WriteLoEn(WriteLoEn), .WriteData(WriteData),
    .ReadHi(ReadHi), .ReadLo(ReadLo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int          nChecks = 0;
  int          nFails = 0;
  int          nPushed = 0;
  int          nDone = 0;
  logic [63:0] expQ[$];
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation, straight from the instruction semantics.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    logic [63:0] p;
    int          sa;
    int          sb;
    if (op[2:1] == 2'b11) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op[0]) return {a % b, a / b};
      sa = $signed(a);
      sb = $signed(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    if (op[0]) p = {32'd0, a} * {32'd0, b};
    else       p = 64'(longint'($signed(a)) * longint'($signed(b)));
    case (op[2:1])
      2'b01:   return hilo + p;
      2'b10:   return hilo - p;
      default: return p;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (Done) begin
      nDone++;
      if (expQ.size() == 0) begin
        nFails++;
        nChecks++;
        $display("FAIL unexpected_done: got Done=1, required no pending result");
      end else begin
        check("hilo_result", {ReadHi, ReadLo}, expQ.pop_front());
      end
    end
  end

  task automatic mtWrite(input logic wh, input logic wl, input logic [31:0] wd);
    @(negedge Clk);
    WriteHiEn = wh; WriteLoEn = wl; WriteData = wd;
    @(posedge Clk); #1;
    WriteHiEn = 1'b0; WriteLoEn = 1'b0;
    if (wh) mHi = wd;
    if (wl) mLo = wd;
    check("mt_write", {ReadHi, ReadLo}, {mHi, mLo});
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wh, input logic wl, input logic [31:0] wd, input int disturbAt);
    int busyCnt;
    int expBusy;
    logic [63:0] r;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    WriteHiEn = wh; WriteLoEn = wl; WriteData = wd;
    if (wh) mHi = wd;
    if (wl) mLo = wd;
    r = model(op, a, b, {mHi, mLo});
    {mHi, mLo} = r;
    expQ.push_back(r);
    nPushed++;
    expBusy = (op[2:1] == 2'b11) ? 33 : 1;
    @(posedge Clk); #1;
    Start = 1'b0; WriteHiEn = 1'b0; WriteLoEn = 1'b0;
    Op = 3'($urandom); A = $urandom; B = $urandom;
    busyCnt = 0;
    while (Busy && busyCnt < 100) begin
      busyCnt++;
      if (busyCnt == disturbAt) begin
        Start = 1'b1; WriteLoEn = 1'b1; WriteHiEn = 1'b1; WriteData = $urandom;
      end
      @(posedge Clk); #1;
      Start = 1'b0; WriteLoEn = 1'b0; WriteHiEn = 1'b0;
    end
    check("busy_cycles", 64'(busyCnt), 64'(expBusy));
    check("done_after_busy", {63'd0, Done}, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d;
    repeat (3) @(negedge Clk);
    check("reset_state", {ReadHi, ReadLo, 62'd0, Busy, Done}, 128'd0);
    Rst = 1'b1;

    issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'd0, 0);
    check("mult_neg", {ReadHi, ReadLo}, 64'hFFFF_FFFF_FFFF_FFEB);

    mtWrite(1'b1, 1'b1, 32'd0);
    mtWrite(1'b0, 1'b1, 32'd32);
    issue(3'b100, 32'd32, 32'd32, 1'b0, 1'b0, 32'd0, 0);
    check("msub", {ReadHi, ReadLo}, 64'hFFFF_FFFF_FFFF_FC20);
    mtWrite(1'b1, 1'b1, 32'd0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);

    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 0);
    check("div_neg", {ReadHi, ReadLo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'b111, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 0);
    issue(3'b111, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 0);
    check("divu_by_zero", {ReadHi, ReadLo}, 64'h0000_0005_FFFF_FFFF);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);

    issue(3'b110, 32'd1000, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, 5);
    mtWrite(1'b1, 1'b0, 32'd0);
    issue(3'b010, 32'd2, 32'd3, 1'b0, 1'b1, 32'd10, 0);
    check("madd_on_mtlo", {32'd0, ReadLo}, 64'd16);

    // Asynchronous abort in the middle of a divide.
    @(negedge Clk);
    Start = 1'b1; Op = 3'b110; A = 32'd12345; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check("abort_state", {ReadHi, ReadLo, 62'd0, Busy, Done}, 128'd0);
    Rst = 1'b1;
    mHi = 32'd0; mLo = 32'd0;
    repeat (40) @(posedge Clk);
    #1;
    check("abort_idle", {ReadHi, ReadLo, 62'd0, Busy, Done}, 128'd0);
    issue(3'b001, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 0);
    check("multu_after_abort", {ReadHi, ReadLo}, 64'd42);

    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 4) == 0) ? 3 : 0;
      issue(3'($urandom_range(0, 7)), pick(), pick(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, d);
    end

    repeat (3) @(negedge Clk);
    check("queue_drained", 64'(expQ.size()), 64'd0);
    check("done_count", 64'(nDone), 64'(nPushed));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
